// File: rtl/mux_tree_cfg_writer.sv
// Serialises one 4-bit tap-buffered mux config word per request into the ccff chain.
// Optional MUX_CFG_SEL_CHECK_EN: flag selects above 8 in a sticky cfg_err.
//
// state | meaning
// IDLE  | waiting for a request; cfg_ready high once out of reset and not clearing
// SHIFT | four cycles driving sram[3..0] onto ccff_head with ccff_en high
module mux_tree_cfg_writer #(
    parameter int NUM_MUX = 4
) (
    input  logic       prog_clk,
    input  logic       prog_reset_n,
    input  logic       cfg_clear,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_sel,
    output logic       cfg_ready,
    output logic       ccff_head,
    output logic       ccff_en,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int CNT_W = $clog2(NUM_MUX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_MUX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sram_q, sram_d;
    logic [1:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             run_q, run_d;
    logic             handshake;

    function automatic logic [3:0] encode(input logic [3:0] sel);
        logic [3:0] sram;
        case (sel)
            4'd0:    sram = 4'b1111;
            4'd1:    sram = 4'b1110;
            4'd2:    sram = 4'b1100;
            4'd3:    sram = 4'b1010;
            4'd4:    sram = 4'b1000;
            4'd5:    sram = 4'b0110;
            4'd6:    sram = 4'b0100;
            4'd7:    sram = 4'b0010;
            default: sram = 4'b0000;
        endcase
        return sram;
    endfunction

    // run_q keeps cfg_ready low until the first clock after reset release
    assign run_d     = 1'b1;
    assign cfg_ready = (state_q == IDLE) && run_q && !cfg_clear;
    assign handshake = cfg_ready && cfg_valid;

    always_comb begin
        state_d = state_q;
        sram_d  = sram_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_clear) begin
                    cnt_d = '0;
                end else if (handshake) begin
                    sram_d  = encode(cfg_sel);
                    bit_d   = 2'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_clear) begin
                    state_d = IDLE;
                    bit_d   = 2'd0;
                    cnt_d   = '0;
                end else begin
                    bit_d = bit_q + 2'd1;
                    if (bit_q == 2'd3) begin
                        state_d = IDLE;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= IDLE;
            sram_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sram_q  <= sram_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    // MSB first: bit index 3 - bit_q, which is ~bit_q for a 2-bit count
    assign ccff_en   = (state_q == SHIFT);
    assign ccff_head = ccff_en && sram_q[~bit_q];
    assign cfg_done  = done_q;

`ifdef MUX_CFG_SEL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (cfg_clear) begin
            err_d = 1'b0;
        end else if (handshake && (cfg_sel > 4'd8)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_tree_cfg_writer.sv
// Scoreboard bench: driver pushes expected chain bits and done points, monitor compares on negedge.
module tb_mux_tree_cfg_writer;

    localparam int NUM_MUX = 4;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       cfg_clear;
    logic       cfg_valid;
    logic [3:0] cfg_sel;
    logic       cfg_ready;
    logic       ccff_head;
    logic       ccff_en;
    logic       cfg_done;
    logic       cfg_err;

    mux_tree_cfg_writer #(.NUM_MUX(NUM_MUX)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .cfg_clear    (cfg_clear),
        .cfg_valid    (cfg_valid),
        .cfg_sel      (cfg_sel),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // reference model state, written by the driver only
    logic exp_bits[$];
    int   exp_done_q[$];
    int   pushed_bits = 0;
    int   words = 0;
    logic exp_err = 1'b0;
    logic end_req = 1'b0;

    // monitor state
    int   checks = 0;
    int   failures = 0;
    int   bits_seen = 0;
    logic prev_en = 1'b0;
    logic mon_fin = 1'b0;
    logic rel = 1'b0;

    always @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) rel <= 1'b0;
        else               rel <= 1'b1;
    end

    function automatic logic [3:0] exp_word(input logic [3:0] sel);
        int v;
        if (sel == 4'd0)      v = 15;
        else if (sel <= 4'd8) v = 16 - 2 * int'(sel);
        else                  v = 0;
        return 4'(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge prog_clk) begin
        logic b;
        int   d;
        if (!prog_reset_n) begin
            chk("rst_en", int'(ccff_en), 0);
            chk("rst_head", int'(ccff_head), 0);
            chk("rst_done", int'(cfg_done), 0);
            chk("rst_ready", int'(cfg_ready), 0);
            chk("rst_err", int'(cfg_err), 0);
        end else begin
            chk("ready", int'(cfg_ready), int'(rel && !cfg_clear && !ccff_en));
            if (ccff_en) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_bit: got head=%0d expected no shift at %0t", ccff_head, $time);
                end else begin
                    b = exp_bits.pop_front();
                    if (ccff_head !== b) begin
                        failures++;
                        $display("FAIL head_bit%0d: got %0d expected %0d at %0t", bits_seen, ccff_head, b, $time);
                    end
                end
                bits_seen++;
            end else begin
                chk("head_idle", int'(ccff_head), 0);
            end
            if (cfg_done) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got pulse expected none at bit %0d", bits_seen);
                end else begin
                    d = exp_done_q.pop_front();
                    if (d != bits_seen) begin
                        failures++;
                        $display("FAIL done_pos: got bit %0d expected bit %0d", bits_seen, d);
                    end
                end
                chk("done_after_shift", int'(prev_en), 1);
            end
            chk("err", int'(cfg_err), int'(exp_err));
        end
        prev_en = ccff_en;
        if (end_req && !mon_fin) begin
            chk("bits_left", exp_bits.size(), 0);
            chk("done_left", exp_done_q.size(), 0);
            mon_fin = 1'b1;
        end
    end

    // nbits < 4 means the word is cut short and must not count
    task automatic send(input logic [3:0] sel, input int nbits);
        logic [3:0] w;
        int k;
        w = exp_word(sel);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        k = 0;
        @(negedge prog_clk);
        while (!cfg_ready && k < 50) begin
            @(negedge prog_clk);
            k++;
        end
        if (!cfg_ready) begin
            $display("FAIL ready_timeout: got cfg_ready=0 expected 1 within 50 cycles");
            $fatal(1, "ready timeout");
        end
        for (int i = 0; i < nbits; i++) exp_bits.push_back(w[3-i]);
        pushed_bits += nbits;
        if (nbits == 4) begin
            words++;
            if (words == NUM_MUX) begin
                words = 0;
                exp_done_q.push_back(pushed_bits);
            end
        end
        @(posedge prog_clk);
        #1;
`ifdef MUX_CFG_SEL_CHECK_EN
        if (sel > 4'd8) exp_err = 1'b1;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge prog_clk);
        #1;
    endtask

    task automatic clear_pulse(input int n);
        cfg_clear = 1'b1;
        idle(n);
        cfg_clear = 1'b0;
        words = 0;
        exp_err = 1'b0;
    endtask

    initial begin
        logic [3:0] seq[4];
        int g;
        prog_reset_n = 1'b0;
        cfg_clear = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel = 4'd0;
        idle(3);
        prog_reset_n = 1'b1;

        send(4'd0, 4);
        cfg_valid = 1'b0;
        idle(6);
        clear_pulse(1);

        seq = '{4'd3, 4'd6, 4'd8, 4'd1};
        for (int i = 0; i < 4; i++) send(seq[i], 4);
        cfg_valid = 1'b0;
        idle(7);

        send(4'd5, 2);
        cfg_valid = 1'b0;
        idle(1);
        clear_pulse(1);
        for (int i = 0; i < 4; i++) send(4'(i + 2), 4);
        cfg_valid = 1'b0;
        idle(7);

        send(4'd12, 4);
        cfg_valid = 1'b0;
        idle(8);
        clear_pulse(1);
        idle(2);

        cfg_sel = 4'd4;
        cfg_valid = 1'b1;
        clear_pulse(2);
        send(4'd4, 4);
        cfg_valid = 1'b0;
        idle(7);

        send(4'd7, 2);
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b0;
        words = 0;
        exp_err = 1'b0;
        idle(2);
        prog_reset_n = 1'b1;
        send(4'd2, 4);
        cfg_valid = 1'b0;
        idle(6);

        for (int i = 0; i < 40; i++) begin
            send(4'($urandom_range(0, 15)), 4);
            g = $urandom_range(0, 2);
            if (g > 0) begin
                cfg_valid = 1'b0;
                idle(g);
            end
        end
        cfg_valid = 1'b0;
        idle(10);

        end_req = 1'b1;
        repeat (5) @(negedge prog_clk);
        #1;
        if (!mon_fin) $display("FAIL monitor_end: got unfinished expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + (mon_fin ? 0 : 1));
        $finish;
    end

endmodule
